// File: rtl/playback_fetch_pkg.sv
// Shared definitions for the playback prefetch path.
// Contents:
//   PLAYBACK_WORD_W - width of one playback word (16 channels x {enable,out})
//   mem_t           - per-channel view of a playback word
//   pack_word/unpack_word - convert between mem_t and the flat 32-bit word.
//     Channel i lives in bits [2i+1:2i], with enable as the MSB of the pair.
package playback_fetch_pkg;

  localparam int PLAYBACK_WORD_W = 32;
  localparam int PLAYBACK_CHANS  = PLAYBACK_WORD_W / 2;

  typedef struct packed {
    logic en;
    logic out;
  } play_pair_t;

  typedef play_pair_t [PLAYBACK_CHANS-1:0] mem_t;

  function automatic logic [PLAYBACK_WORD_W-1:0] pack_word(input mem_t m);
    logic [PLAYBACK_WORD_W-1:0] w;
    for (int i = 0; i < PLAYBACK_CHANS; i++) begin
      w[2*i+1] = m[i].en;
      w[2*i]   = m[i].out;
    end
    return w;
  endfunction

  function automatic mem_t unpack_word(input logic [PLAYBACK_WORD_W-1:0] w);
    mem_t m;
    for (int i = 0; i < PLAYBACK_CHANS; i++) begin
      m[i].en  = w[2*i+1];
      m[i].out = w[2*i];
    end
    return m;
  endfunction

endpackage

// File: rtl/playback_fetch_word_fifo.sv
// playback_word_fifo: DEPTH x 32-bit circular buffer between the RAM return
// path and the head register of playback_fetch.
// Ports:
//   i_clk, i_reset       - clock, synchronous active-high reset
//   i_flush              - empties the buffer (wins over push/pop)
//   i_push, i_wdata      - write one word at the tail
//   i_pop                - discard the head word (caller guarantees non-empty)
//   o_rdata              - current head word
//   o_count, o_empty     - occupancy
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module playback_word_fifo
  import playback_fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  logic [PLAYBACK_WORD_W-1:0] i_wdata,
  input  logic                       i_pop,
  output logic [PLAYBACK_WORD_W-1:0] o_rdata,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PLAYBACK_WORD_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]           r_wr_ptr;
  logic [PTR_W-1:0]           r_rd_ptr;
  logic [PTR_W:0]             r_count;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: ;
      endcase
    end
  end

  // Storage needs no reset; occupancy tracking decides what is live.
  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/playback_fetch.sv
// playback_fetch: prefetch stage ahead of the playback unit. Streams
// word_count consecutive 32-bit words from a synchronous-read RAM starting at
// base_addr, presents the head word continuously, and pops it on each rising
// edge of the playback unit's advance request.
// Ports:
//   i_clk, i_reset           - clock, synchronous active-high reset
//   i_start                  - 1-cycle pulse: load i_base_addr/i_word_count, (re)start
//   o_mem_rd_en, o_mem_addr  - RAM read strobe/address (data back MEM_LAT cycles later)
//   i_mem_rdata              - RAM read data
//   i_adv                    - advance level from the playback unit
//   o_word_out, o_word_valid - head word and its valid flag
//   o_underrun               - sticky: a pop found no word while words were outstanding
//   o_done                   - all words fetched and consumed
// Optional build macro PLAYBACK_FETCH_LOOP_EN: when defined, the block restarts
// from the latched base/count whenever the count is exhausted (continuous loop).
// Buffering = one head register plus a BUF_DEPTH-entry FIFO; reads are only
// issued while (words held + reads in flight) < BUF_DEPTH, so the FIFO never
// overflows. BUF_DEPTH >= MEM_LAT+1 keeps the read pipe full in steady state.
module playback_fetch
  import playback_fetch_pkg::*;
#(
  parameter int ADDR_W    = 12,
  parameter int MEM_LAT   = 2,
  parameter int BUF_DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_start,
  input  logic [ADDR_W-1:0]          i_base_addr,
  input  logic [ADDR_W:0]            i_word_count,
  output logic                       o_mem_rd_en,
  output logic [ADDR_W-1:0]          o_mem_addr,
  input  logic [PLAYBACK_WORD_W-1:0] i_mem_rdata,
  input  logic                       i_adv,
  output logic [PLAYBACK_WORD_W-1:0] o_word_out,
  output logic                       o_word_valid,
  output logic                       o_underrun,
  output logic                       o_done
);

`ifdef PLAYBACK_FETCH_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 2;
  localparam logic [ADDR_W:0] REM_ONE = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} fetch_state_t;

  fetch_state_t         r_state;
  logic                 r_adv_q;
  logic [ADDR_W-1:0]    r_base_lat;
  logic [ADDR_W:0]      r_count_lat;
  logic [ADDR_W-1:0]    r_mem_addr;
  logic [ADDR_W:0]      r_remaining;
  logic [CNT_W-1:0]     r_inflight;
  logic [MEM_LAT-1:0]   r_vld_pipe;
  mem_t                 r_head;
  logic                 r_word_valid;
  logic                 r_underrun;
  logic                 r_done;

  logic                       w_pop_req;
  logic                       w_ret;
  logic                       w_issue;
  logic                       w_pop;
  logic                       w_head_free;
  logic                       w_fifo_pop;
  logic                       w_bypass;
  logic                       w_push;
  logic                       w_outstanding;
  logic                       w_underrun_ev;
  logic [PLAYBACK_WORD_W-1:0] w_fifo_rdata;
  logic [PTR_W:0]             w_fifo_count;
  logic                       w_fifo_empty;
  logic [CNT_W-1:0]           w_occ;

  assign w_pop_req = i_adv & ~r_adv_q;

  // A start cycle discards everything: the tagged return is not written and
  // no read is issued against the old address.
  assign w_ret = r_vld_pipe[MEM_LAT-1] & ~i_start;
  assign w_occ = CNT_W'(w_fifo_count) + CNT_W'(r_word_valid);
  assign w_issue = ~i_start && (r_state == FETCH) && (r_remaining != '0) &&
                   ((w_occ + r_inflight) < CNT_W'(BUF_DEPTH));

  // Head register refills from the FIFO, or straight from the RAM when the
  // FIFO is empty, so an empty buffer costs no extra cycle.
  assign w_pop       = w_pop_req & r_word_valid & ~i_start;
  assign w_head_free = ~r_word_valid | w_pop;
  assign w_fifo_pop  = w_head_free & ~w_fifo_empty & ~i_start;
  assign w_bypass    = w_head_free & w_fifo_empty & w_ret;
  assign w_push      = w_ret & ~w_bypass;

  assign w_outstanding = (r_remaining != '0) || (r_inflight != '0);
  // Underrun: a pop that finds no word (now, or to replace the popped one)
  // while words are still owed.
  assign w_underrun_ev = w_pop_req & ~i_start & w_outstanding &
                         (~r_word_valid | (w_fifo_empty & ~w_ret));

  playback_word_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_flush (i_start),
    .i_push  (w_push),
    .i_wdata (i_mem_rdata),
    .i_pop   (w_fifo_pop),
    .o_rdata (w_fifo_rdata),
    .o_count (w_fifo_count),
    .o_empty (w_fifo_empty)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= IDLE;
      r_adv_q      <= 1'b1;
      r_base_lat   <= '0;
      r_count_lat  <= '0;
      r_mem_addr   <= '0;
      r_remaining  <= '0;
      r_inflight   <= '0;
      r_vld_pipe   <= '0;
      r_head       <= '0;
      r_word_valid <= 1'b0;
      r_underrun   <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_adv_q <= i_adv;
      if (i_start) begin
        r_state      <= FETCH;
        r_base_lat   <= i_base_addr;
        r_count_lat  <= i_word_count;
        r_mem_addr   <= i_base_addr;
        r_remaining  <= i_word_count;
        r_inflight   <= '0;
        r_vld_pipe   <= '0;
        r_head       <= '0;
        r_word_valid <= 1'b0;
        r_underrun   <= 1'b0;
        r_done       <= 1'b0;
      end else begin
        r_vld_pipe[0] <= w_issue;
        for (int i = 1; i < MEM_LAT; i++) r_vld_pipe[i] <= r_vld_pipe[i-1];

        case ({w_issue, w_ret})
          2'b10:   r_inflight <= r_inflight + CNT_W'(1);
          2'b01:   r_inflight <= r_inflight - CNT_W'(1);
          default: ;
        endcase

        if (w_issue) begin
          if (LOOP_EN && (r_remaining == REM_ONE)) begin
            r_remaining <= r_count_lat;
            r_mem_addr  <= r_base_lat;
          end else begin
            r_remaining <= r_remaining - REM_ONE;
            r_mem_addr  <= r_mem_addr + ADDR_W'(1);
          end
        end

        if (w_fifo_pop) begin
          r_head       <= unpack_word(w_fifo_rdata);
          r_word_valid <= 1'b1;
        end else if (w_bypass) begin
          r_head       <= unpack_word(i_mem_rdata);
          r_word_valid <= 1'b1;
        end else if (w_pop) begin
          r_word_valid <= 1'b0;
        end

        if (w_underrun_ev) r_underrun <= 1'b1;

        case (r_state)
          FETCH: if ((r_remaining == '0) && (r_inflight == '0)) r_state <= DRAIN;
          DRAIN: if (w_fifo_empty && !r_word_valid) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign o_mem_rd_en  = w_issue;
  assign o_mem_addr   = r_mem_addr;
  assign o_word_out   = pack_word(r_head);
  assign o_word_valid = r_word_valid;
  assign o_underrun   = r_underrun;
  assign o_done       = r_done;

endmodule

// File: tb/tb_playback_fetch.sv
// Bench for playback_fetch: RAM model returns 0xA5A50000 | address after
// MEM_LAT cycles; expected words are queued at start and compared as they
// reach the head.
module tb_playback_fetch;
  localparam int ADDR_W    = 12;
  localparam int MEM_LAT   = 2;
  localparam int BUF_DEPTH = 4;

  logic              clk = 1'b0;
  logic              reset, start, adv;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   word_count;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rdata, word_out;
  logic              word_valid, underrun, done;

  int errors = 0;
  int checks = 0;
  logic [31:0]       exp_q[$];
  logic [ADDR_W-1:0] rd_log[$];
  logic [31:0]       ram_pipe [MEM_LAT];

  always #5 clk = ~clk;

  playback_fetch #(.ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT), .BUF_DEPTH(BUF_DEPTH)) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_base_addr(base_addr),
    .i_word_count(word_count), .o_mem_rd_en(mem_rd_en), .o_mem_addr(mem_addr),
    .i_mem_rdata(mem_rdata), .i_adv(adv), .o_word_out(word_out),
    .o_word_valid(word_valid), .o_underrun(underrun), .o_done(done)
  );

  // Synchronous RAM with MEM_LAT register stages.
  always @(posedge clk) begin
    if (mem_rd_en) rd_log.push_back(mem_addr);
    ram_pipe[0] <= 32'hA5A5_0000 | 32'(mem_addr);
    for (int i = 1; i < MEM_LAT; i++) ram_pipe[i] <= ram_pipe[i-1];
  end
  assign mem_rdata = ram_pipe[MEM_LAT-1];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] b, input int n);
    logic [ADDR_W-1:0] a;
    start = 1'b1; base_addr = b; word_count = (ADDR_W+1)'(n);
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      a = ADDR_W'(32'(b) + i);
      exp_q.push_back(32'hA5A5_0000 | 32'(a));
    end
    tick();
    start = 1'b0;
  endtask

  task automatic pulse(input int hi);
    adv = 1'b1; repeat (hi) tick();
    adv = 1'b0; repeat (hi) tick();
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (word_valid) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic consume(input int n, input int hi, input string tag);
    bit ok;
    logic [31:0] e;
    for (int k = 0; k < n; k++) begin
      wait_valid(60, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL %s word%0d timeout: word_valid=0 required 1", tag, k);
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL %s word%0d unexpected: word_out=%h required none", tag, k, word_out);
      end else begin
        e = exp_q.pop_front();
        if (word_out !== e) begin
          errors++;
          $display("FAIL %s word%0d: word_out=%h required %h", tag, k, word_out, e);
        end
      end
      pulse(hi);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; adv = 1'b1; base_addr = '0; word_count = '0;
    repeat (3) tick();
    checks++;
    if ({mem_rd_en, mem_addr, word_out, word_valid, underrun, done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rd_en=%b addr=%h word=%h valid=%b und=%b done=%b required all 0",
               mem_rd_en, mem_addr, word_out, word_valid, underrun, done);
    end
    reset = 1'b0;
    repeat (3) tick();
    checks++;
    if ({word_valid, underrun, done, mem_rd_en} !== 4'b0) begin
      errors++;
      $display("FAIL reset_release: valid=%b und=%b done=%b rd_en=%b required 0",
               word_valid, underrun, done, mem_rd_en);
    end
    adv = 1'b0; tick();
  endtask

  task automatic test_single_pass();
    logic [31:0] e;
    do_start(12'h010, 3);
    tick(); tick();
    checks++;
    if (word_valid !== 1'b0) begin
      errors++; $display("FAIL sp_early_valid: word_valid=%b required 0", word_valid);
    end
    tick();
    e = exp_q.pop_front();
    checks++;
    if (word_valid !== 1'b1 || word_out !== e) begin
      errors++; $display("FAIL sp_latency: valid=%b word=%h required 1/%h", word_valid, word_out, e);
    end
    for (int k = 0; k < 3; k++) begin
      adv = 1'b1; tick();
      checks++;
      if (k < 2) begin
        e = exp_q.pop_front();
        if (word_valid !== 1'b1 || word_out !== e) begin
          errors++; $display("FAIL sp_pop%0d: valid=%b word=%h required 1/%h", k, word_valid, word_out, e);
        end
      end else if (word_valid !== 1'b0) begin
        errors++; $display("FAIL sp_last_pop: word_valid=%b required 0", word_valid);
      end
      repeat (19) tick();
      adv = 1'b0; repeat (20) tick();
    end
    checks++;
    if (done !== 1'b1 || underrun !== 1'b0) begin
      errors++; $display("FAIL sp_end: done=%b underrun=%b required 1/0", done, underrun);
    end
  endtask

  task automatic test_held_adv();
    bit ok;
    logic [31:0] e;
    do_start(12'h020, 3);
    wait_valid(20, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || word_out !== e) begin
      errors++; $display("FAIL held_first: valid=%b word=%h required 1/%h", word_valid, word_out, e);
    end
    adv = 1'b1; repeat (200) tick();
    checks++;
    if (word_valid !== 1'b1 || word_out !== exp_q[0]) begin
      errors++; $display("FAIL held_one_pop: valid=%b word=%h required 1/%h", word_valid, word_out, exp_q[0]);
    end
    adv = 1'b0; tick();
    consume(2, 2, "held_rest");
    tick();
    checks++;
    if (done !== 1'b1 || word_valid !== 1'b0) begin
      errors++; $display("FAIL held_done: done=%b valid=%b required 1/0", done, word_valid);
    end
  endtask

  task automatic test_underrun();
    do_start(12'h200, 8);
    adv = 1'b1; tick();
    adv = 1'b0; tick();
    checks++;
    if (underrun !== 1'b1) begin
      errors++; $display("FAIL underrun_set: underrun=%b required 1", underrun);
    end
    consume(8, 2, "underrun_words");
    repeat (3) tick();
    checks++;
    if (underrun !== 1'b1 || done !== 1'b1) begin
      errors++; $display("FAIL underrun_sticky: underrun=%b done=%b required 1/1", underrun, done);
    end
  endtask

  task automatic test_restart();
    do_start(12'h300, 8);
    checks++;
    if (underrun !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL restart_clear: underrun=%b done=%b required 0/0", underrun, done);
    end
    tick();
    do_start(12'h100, 4);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (word_valid !== 1'b0) begin
        errors++; $display("FAIL restart_stale c%0d: valid=%b word=%h required 0", i, word_valid, word_out);
      end
      tick();
    end
    consume(4, 2, "restart_words");
    tick();
    checks++;
    if (done !== 1'b1 || underrun !== 1'b0) begin
      errors++; $display("FAIL restart_end: done=%b underrun=%b required 1/0", done, underrun);
    end
  endtask

  task automatic test_zero_count();
    int rd = 0;
    rd_log.delete();
    do_start(12'h050, 0);
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL zero_done_early: done=%b required 0", done);
    end
    for (int i = 0; i < 2; i++) begin
      if (mem_rd_en) rd++;
      tick();
    end
    checks++;
    if (done !== 1'b1 || rd != 0 || rd_log.size() != 0) begin
      errors++; $display("FAIL zero_count: done=%b reads=%0d required 1/0", done, rd_log.size());
    end
  endtask

  task automatic test_wrap();
    rd_log.delete();
    do_start(12'hFFF, 2);
    consume(2, 2, "wrap_words");
    checks++;
    if (rd_log.size() != 2) begin
      errors++; $display("FAIL wrap_reads: count=%0d required 2", rd_log.size());
    end else if (rd_log[0] !== 12'hFFF || rd_log[1] !== 12'h000) begin
      errors++; $display("FAIL wrap_addr: %h %h required fff 000", rd_log[0], rd_log[1]);
    end
    tick();
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL wrap_done: done=%b required 1", done);
    end
  endtask

  task automatic test_loop();
    do_start(12'h040, 2);
    for (int i = 0; i < 4; i++) exp_q.push_back(32'hA5A5_0040 | 32'(i % 2));
    consume(6, 2, "loop_words");
    checks++;
    if (done !== 1'b0 || word_valid !== 1'b1) begin
      errors++; $display("FAIL loop_running: done=%b valid=%b required 0/1", done, word_valid);
    end
  endtask

  initial begin
    test_reset();
`ifdef PLAYBACK_FETCH_LOOP_EN
    test_loop();
`else
    test_single_pass();
    test_held_adv();
    test_underrun();
    test_restart();
    test_zero_count();
    test_wrap();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
